// File: rtl/ctl_pkg.sv
// rtl/ctl_pkg.sv - shared state encoding, widths and BCD helper for the round sequencer
package ctl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    SPAWN     = 3'd2,
    FLYING    = 3'd3,
    ESCAPE    = 3'd4,
    NEXT      = 3'd5,
    GAME_OVER = 3'd6
  } round_state_t;

  localparam int AMMO_W = 3;
  localparam int DUCK_W = 4;

  // {tens, units} of a duck count; DUCK_W bits never exceed 15
  function automatic logic [7:0] to_bcd(input logic [DUCK_W-1:0] v);
    if (v >= DUCK_W'(10)) begin
      return {4'd1, v - DUCK_W'(10)};
    end
    return {4'd0, v};
  endfunction

endpackage

// File: rtl/ctl_edge_det.sv
// rtl/ctl_edge_det.sv - registered one-bit rising-edge detector
module ctl_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;
  logic r_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_prev <= i_d;
      r_rise <= i_d & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/ctl_round.sv
// rtl/ctl_round.sv - duck-hunt round sequencer; CTL_ROUND_HEX_EN adds hex0/hex1 ducks_left digits
module ctl_round
  import ctl_pkg::*;
#(
  parameter int SHOTS_PER_DUCK  = 3,
  parameter int DUCKS_PER_ROUND = 10,
  parameter int FLY_TICKS       = 300,
  parameter int ESCAPE_TICKS    = 60,
  parameter int PASS_SCORE      = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              trigger,
  input  logic              hit,
  input  logic              tick,
  input  logic [3:0]        score_ctr,
  output logic              reset_score,
  output logic              spawn_duck,
  output logic              duck_escape,
  output logic [AMMO_W-1:0] ammo,
  output logic [DUCK_W-1:0] ducks_left,
  output logic              game_over,
  output logic              pass,
  output logic [2:0]        state_dbg
`ifdef CTL_ROUND_HEX_EN
  ,
  output logic [3:0]        hex0,
  output logic [3:0]        hex1
`endif
);

  localparam int CNT_MAXV = (FLY_TICKS > ESCAPE_TICKS) ? FLY_TICKS : ESCAPE_TICKS;
  localparam int CW       = $clog2(CNT_MAXV + 1);

  localparam logic [CW-1:0]     CNT_SAT    = CW'(CNT_MAXV);
  localparam logic [CW-1:0]     FLY_LAST   = CW'(FLY_TICKS - 1);
  localparam logic [CW-1:0]     ESC_LAST   = CW'(ESCAPE_TICKS - 1);
  localparam logic [AMMO_W-1:0] AMMO_INIT  = AMMO_W'(SHOTS_PER_DUCK);
  localparam logic [DUCK_W-1:0] DUCKS_INIT = DUCK_W'(DUCKS_PER_ROUND);
  localparam logic [3:0]        PASS_THR   = 4'(PASS_SCORE);

  round_state_t      r_state;
  round_state_t      w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [AMMO_W-1:0] r_ammo;
  logic [DUCK_W-1:0] r_ducks;
  logic              r_reset_score;
  logic              r_spawn;
  logic              r_escape;
  logic              r_game_over;
  logic              r_pass;
  logic              w_start;
  logic              w_trig;
  logic              w_hit;
  logic              w_enter;
  logic              w_shot;
  logic              w_count;

  ctl_edge_det u_start_edge (.clk(clk), .rst_n(rst_n), .i_d(start),   .o_rise(w_start));
  ctl_edge_det u_trig_edge  (.clk(clk), .rst_n(rst_n), .i_d(trigger), .o_rise(w_trig));
  ctl_edge_det u_hit_edge   (.clk(clk), .rst_n(rst_n), .i_d(hit),     .o_rise(w_hit));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (w_start) w_state_nxt = CLEAR;
      CLEAR:     w_state_nxt = SPAWN;
      SPAWN:     w_state_nxt = FLYING;
      FLYING: begin
        // hit wins over everything; an empty gun exits one cycle after the last shot
        if (w_hit)                          w_state_nxt = NEXT;
        else if (tick && r_cnt >= FLY_LAST) w_state_nxt = ESCAPE;
        else if (r_ammo == '0)              w_state_nxt = ESCAPE;
      end
      ESCAPE:    if (tick && r_cnt >= ESC_LAST) w_state_nxt = NEXT;
      NEXT:      w_state_nxt = (r_ducks == '0) ? GAME_OVER : SPAWN;
      GAME_OVER: if (w_start) w_state_nxt = CLEAR;
      default:   w_state_nxt = IDLE;
    endcase
  end

  assign w_enter = (w_state_nxt != r_state);
  assign w_shot  = (r_state == FLYING) && !w_hit && w_trig && (r_ammo != '0);
  assign w_count = tick && (r_cnt != CNT_SAT) && (r_state == FLYING || r_state == ESCAPE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_ammo        <= '0;
      r_ducks       <= '0;
      r_reset_score <= 1'b0;
      r_spawn       <= 1'b0;
      r_escape      <= 1'b0;
      r_game_over   <= 1'b0;
      r_pass        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_reset_score <= (w_state_nxt == CLEAR);
      r_spawn       <= (w_state_nxt == SPAWN);
      r_escape      <= (w_state_nxt == ESCAPE);
      r_game_over   <= (w_state_nxt == GAME_OVER);

      // ticks landing on a transition cycle are dropped by the entry clear
      if (w_enter)      r_cnt <= '0;
      else if (w_count) r_cnt <= r_cnt + 1'b1;

      if (w_state_nxt == SPAWN) r_ammo <= AMMO_INIT;
      else if (w_shot)          r_ammo <= r_ammo - 1'b1;

      if (w_state_nxt == CLEAR)                         r_ducks <= DUCKS_INIT;
      else if (w_state_nxt == SPAWN && r_ducks != '0)   r_ducks <= r_ducks - 1'b1;

      if (w_state_nxt == GAME_OVER && r_state != GAME_OVER) r_pass <= (score_ctr >= PASS_THR);
      else if (w_state_nxt != GAME_OVER)                    r_pass <= 1'b0;
    end
  end

`ifdef CTL_ROUND_HEX_EN
  logic [3:0] r_hex0;
  logic [3:0] r_hex1;
  logic [7:0] w_bcd;

  assign w_bcd = to_bcd(r_ducks);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hex0 <= '0;
      r_hex1 <= '0;
    end else begin
      r_hex0 <= w_bcd[3:0];
      r_hex1 <= w_bcd[7:4];
    end
  end

  assign hex0 = r_hex0;
  assign hex1 = r_hex1;
`endif

  assign reset_score = r_reset_score;
  assign spawn_duck  = r_spawn;
  assign duck_escape = r_escape;
  assign ammo        = r_ammo;
  assign ducks_left  = r_ducks;
  assign game_over   = r_game_over;
  assign pass        = r_pass;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_ctl_round.sv
// tb/tb_ctl_round.sv - directed self-checking bench for ctl_round
module tb_ctl_round;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       trigger;
  logic       hit;
  logic       tick;
  logic [3:0] score_ctr;
  logic       reset_score;
  logic       spawn_duck;
  logic       duck_escape;
  logic [2:0] ammo;
  logic [3:0] ducks_left;
  logic       game_over;
  logic       pass;
  logic [2:0] state_dbg;
`ifdef CTL_ROUND_HEX_EN
  logic [3:0] hex0;
  logic [3:0] hex1;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int kills;

  localparam logic [2:0] S_IDLE = 3'd0, S_CLEAR = 3'd1, S_SPAWN = 3'd2, S_FLYING = 3'd3,
                         S_ESCAPE = 3'd4, S_NEXT = 3'd5, S_OVER = 3'd6;

  ctl_round dut (
    .clk(clk), .rst_n(rst_n), .start(start), .trigger(trigger), .hit(hit), .tick(tick),
    .score_ctr(score_ctr), .reset_score(reset_score), .spawn_duck(spawn_duck),
    .duck_escape(duck_escape), .ammo(ammo), .ducks_left(ducks_left), .game_over(game_over),
    .pass(pass), .state_dbg(state_dbg)
`ifdef CTL_ROUND_HEX_EN
    , .hex0(hex0), .hex1(hex1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shoot();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
  endtask

  task automatic last_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic kill_until_over();
    kills = 0;
    for (int k = 0; k < 20 && !game_over; k++) begin
      hit = 1'b1;
      step();
      hit = 1'b0;
      step();
      step();
      step();
      kills++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; trigger = 1'b0; hit = 1'b0; tick = 1'b0; score_ctr = 4'd0;
    step();
    step();
    chk("rst_state", state_dbg, S_IDLE);
    chk("rst_ammo", ammo, 0);
    chk("rst_ducks", ducks_left, 0);
    chk("rst_flags", {reset_score, spawn_duck, duck_escape, game_over, pass}, 0);
    rst_n = 1'b1;

    // start edge: CLEAR two edges later, SPAWN the edge after
    start = 1'b1;
    step();
    start = 1'b0;
    chk("clr_not_yet", reset_score, 0);
    step();
    chk("clr_pulse", reset_score, 1);
    chk("clr_state", state_dbg, S_CLEAR);
    chk("clr_ducks", ducks_left, 10);
    step();
    chk("clr_one_clk", reset_score, 0);
    chk("spawn1", spawn_duck, 1);
    chk("spawn1_ammo", ammo, 3);
    chk("spawn1_ducks", ducks_left, 9);
    step();
    chk("spawn1_one_clk", spawn_duck, 0);
    chk("fly1_state", state_dbg, S_FLYING);
`ifdef CTL_ROUND_HEX_EN
    chk("hex0_9", hex0, 9);
    chk("hex1_0", hex1, 0);
`endif

    // three misses empty the gun
    shoot();
    chk("ammo_2", ammo, 2);
    shoot();
    chk("ammo_1", ammo, 1);
    shoot();
    chk("ammo_0", ammo, 0);
    chk("ammo0_still_fly", state_dbg, S_FLYING);
    step();
    chk("esc_state", state_dbg, S_ESCAPE);
    chk("esc_level", duck_escape, 1);
    ticks(59);
    chk("esc_59", duck_escape, 1);
    last_tick();
    chk("esc_done_state", state_dbg, S_NEXT);
    chk("esc_done_level", duck_escape, 0);
    step();
    chk("spawn2", spawn_duck, 1);
    chk("spawn2_ducks", ducks_left, 8);
    chk("spawn2_ammo", ammo, 3);
    step();

    // hit and trigger together: hit wins, no shot spent
    hit = 1'b1; trigger = 1'b1;
    step();
    hit = 1'b0; trigger = 1'b0;
    step();
    chk("hit_next", state_dbg, S_NEXT);
    chk("hit_ammo", ammo, 3);
    step();
    chk("spawn3", spawn_duck, 1);
    chk("spawn3_ducks", ducks_left, 7);
    step();

    // flight timeout on the 300th tick; shots during ESCAPE ignored
    ticks(299);
    chk("fly_299", state_dbg, S_FLYING);
    last_tick();
    chk("fly_300_esc", state_dbg, S_ESCAPE);
    shoot();
    shoot();
    chk("esc_ammo_kept", ammo, 3);
    chk("esc_still", duck_escape, 1);
    ticks(59);
    last_tick();
    step();
    chk("spawn4_ducks", ducks_left, 6);
    step();

    // finish game one with a passing score
    score_ctr = 4'd6;
    kill_until_over();
    chk("g1_kills", kills, 7);
    chk("g1_over", game_over, 1);
    chk("g1_pass", pass, 1);
    chk("g1_state", state_dbg, S_OVER);
    chk("g1_ducks", ducks_left, 0);

    // restart from GAME_OVER
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("g2_clear", reset_score, 1);
    chk("g2_over_drop", game_over, 0);
    chk("g2_pass_drop", pass, 0);
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("start_ignored", state_dbg, S_FLYING);
    score_ctr = 4'd5;
    kill_until_over();
    chk("g2_kills", kills, 10);
    chk("g2_over", game_over, 1);
    chk("g2_fail", pass, 0);

    // async reset in the middle of a flight
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("g3_fly", state_dbg, S_FLYING);
    shoot();
    chk("g3_ammo", ammo, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", state_dbg, S_IDLE);
    chk("arst_ammo", ammo, 0);
    chk("arst_ducks", ducks_left, 0);
`ifdef CTL_ROUND_HEX_EN
    chk("arst_hex", {hex1, hex0}, 0);
`endif
    step();
    rst_n = 1'b1;
    step();
    chk("arst_no_clear", reset_score, 0);
    chk("arst_idle", state_dbg, S_IDLE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
